// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: depth, fill width and flag calculation.
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic afull;
        logic empty;
        logic aempty;
    } fifo_flags_t;

    function automatic int depth_of(input int asize);
        return 1 << asize;
    endfunction

    // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
    function automatic int fill_width(input int asize);
        return asize + 1;
    endfunction

    function automatic fifo_flags_t calc_flags(input int fill, input int depth,
                                               input int afull, input int aempty);
        fifo_flags_t f;
        f.full   = (fill == depth);
        f.afull  = (fill >= afull);
        f.empty  = (fill == 0);
        f.aempty = (fill <= aempty);
        return f;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: one write port; read port is asynchronous (FWFT) or registered with enable.
module sync_fifo_ram #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4,
    parameter int FWFT  = 1
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [ASIZE-1:0] i_waddr,
    input  logic [DSIZE-1:0] i_wdata,
    input  logic             i_re,
    input  logic [ASIZE-1:0] i_raddr,
    output logic [DSIZE-1:0] o_rdata
);

    logic [DSIZE-1:0] r_mem [1<<ASIZE];

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    if (FWFT != 0) begin : g_fwft
        logic w_unused_rd;
        assign w_unused_rd = i_rst_n ^ i_re;
        assign o_rdata     = r_mem[i_raddr];
    end else begin : g_reg
        logic [DSIZE-1:0] r_rdata;
        // Registered read: capture the head word on an accepted pop, otherwise hold.
        always_ff @(posedge clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_rdata <= '0;
            end else if (i_re) begin
                r_rdata <= r_mem[i_raddr];
            end
        end
        assign o_rdata = r_rdata;
    end

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with selectable FWFT/registered read, thresholds, occupancy and sticky errors.
module sync_fifo_fwft
    import fifo_pkg::*;
#(
    parameter int DSIZE  = 8,
    parameter int ASIZE  = 4,
    parameter int AFULL  = 12,
    parameter int AEMPTY = 2,
    parameter int FWFT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             wafull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             rempty,
    output logic             raempty,
    output logic [ASIZE:0]   fill,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = depth_of(ASIZE);
    localparam int FW    = fill_width(ASIZE);

    if (ASIZE < 1 || AFULL < 1 || AFULL > DEPTH || AEMPTY < 0 || AEMPTY >= AFULL) begin : g_bad_params
        $error("sync_fifo_fwft: illegal ASIZE/AFULL/AEMPTY combination");
    end

    logic [FW-1:0] r_wptr, r_rptr, r_fill;
    logic          r_wfull, r_wafull, r_rempty, r_raempty;
    logic          r_overflow, r_underflow, r_rvalid;
    logic          w_wen, w_ren;
    logic [FW-1:0] w_fill_next;
    fifo_flags_t   w_flags;

    // Accept decisions and next-state flags; flush suppresses both transfers.
    always_comb begin
        w_wen       = winc & ~r_wfull  & ~clr;
        w_ren       = rinc & ~r_rempty & ~clr;
        w_fill_next = r_fill + FW'(w_wen) - FW'(w_ren);
        w_flags     = calc_flags(32'(w_fill_next), DEPTH, AFULL, AEMPTY);
    end

    // Pointers, occupancy, registered flags and sticky error bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_fill      <= '0;
            r_wfull     <= 1'b0;
            r_wafull    <= 1'b0;
            r_rempty    <= 1'b1;
            r_raempty   <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_rvalid    <= 1'b0;
        end else if (clr) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_fill      <= '0;
            r_wfull     <= 1'b0;
            r_wafull    <= 1'b0;
            r_rempty    <= 1'b1;
            r_raempty   <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_rvalid    <= 1'b0;
        end else begin
            if (w_wen) r_wptr <= r_wptr + FW'(1);
            if (w_ren) r_rptr <= r_rptr + FW'(1);
            r_fill    <= w_fill_next;
            r_wfull   <= w_flags.full;
            r_wafull  <= w_flags.afull;
            r_rempty  <= w_flags.empty;
            r_raempty <= w_flags.aempty;
            if (winc & r_wfull)  r_overflow  <= 1'b1;
            if (rinc & r_rempty) r_underflow <= 1'b1;
            r_rvalid  <= w_ren;
        end
    end

    sync_fifo_ram #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE),
        .FWFT  (FWFT)
    ) u_ram (
        .clk     (clk),
        .i_rst_n (rst_n),
        .i_we    (w_wen),
        .i_waddr (r_wptr[ASIZE-1:0]),
        .i_wdata (wdata),
        .i_re    (w_ren),
        .i_raddr (r_rptr[ASIZE-1:0]),
        .o_rdata (rdata)
    );

    assign wfull     = r_wfull;
    assign wafull    = r_wafull;
    assign rempty    = r_rempty;
    assign raempty   = r_raempty;
    assign fill      = r_fill;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign rvalid    = (FWFT != 0) ? ~r_rempty : r_rvalid;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench: one FWFT and one registered-read FIFO driven identically, checked against a queue model.
module tb_sync_fifo_fwft;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, winc, rinc;
    logic [7:0] wdata;

    logic       f1_wfull, f1_wafull, f1_rvalid, f1_rempty, f1_raempty, f1_ovf, f1_unf;
    logic [7:0] f1_rdata;
    logic [4:0] f1_fill;
    logic       f0_wfull, f0_wafull, f0_rvalid, f0_rempty, f0_raempty, f0_ovf, f0_unf;
    logic [7:0] f0_rdata;
    logic [4:0] f0_fill;

    always #5 clk = ~clk;

    sync_fifo_fwft #(.DSIZE(8), .ASIZE(4), .AFULL(12), .AEMPTY(2), .FWFT(1)) u_f1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .winc(winc), .wdata(wdata),
        .wfull(f1_wfull), .wafull(f1_wafull), .rinc(rinc), .rdata(f1_rdata),
        .rvalid(f1_rvalid), .rempty(f1_rempty), .raempty(f1_raempty), .fill(f1_fill),
        .overflow(f1_ovf), .underflow(f1_unf)
    );

    sync_fifo_fwft #(.DSIZE(8), .ASIZE(4), .AFULL(12), .AEMPTY(2), .FWFT(0)) u_f0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .winc(winc), .wdata(wdata),
        .wfull(f0_wfull), .wafull(f0_wafull), .rinc(rinc), .rdata(f0_rdata),
        .rvalid(f0_rvalid), .rempty(f0_rempty), .raempty(f0_raempty), .fill(f0_fill),
        .overflow(f0_ovf), .underflow(f0_unf)
    );

    logic [10:0] stat1, stat0;
    assign stat1 = {f1_fill, f1_wfull, f1_wafull, f1_rempty, f1_raempty, f1_ovf, f1_unf};
    assign stat0 = {f0_fill, f0_wfull, f0_wafull, f0_rempty, f0_raempty, f0_ovf, f0_unf};

    localparam logic [10:0] RESET_STAT = {5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reference model: contents as a queue, sticky bits, and pending registered-read words.
    logic [7:0] m_q[$];
    logic [7:0] m_exp0[$];
    bit         m_ovf, m_unf, m_rv0;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] exp_status();
        int n;
        n = m_q.size();
        return {5'(n), n == 16, n >= 12, n == 0, n <= 2, m_ovf, m_unf};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_exp0.delete();
        m_ovf = 0;
        m_unf = 0;
        m_rv0 = 0;
    endtask

    // Apply the effect of the clock edge just taken with the inputs sampled at it.
    task automatic model_edge();
        bit full, empty;
        if (!rst_n) begin
            model_reset();
        end else if (clr) begin
            m_q.delete();
            m_ovf = 0;
            m_unf = 0;
            m_rv0 = 0;
        end else begin
            full  = (m_q.size() == 16);
            empty = (m_q.size() == 0);
            if (winc && full)  m_ovf = 1;
            if (rinc && empty) m_unf = 1;
            m_rv0 = rinc && !empty;
            if (rinc && !empty) m_exp0.push_back(m_q.pop_front());
            if (winc && !full)  m_q.push_back(wdata);
        end
    endtask

    task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit c);
        winc  = w;
        wdata = d;
        rinc  = r;
        clr   = c;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_f1_stat"}, 32'(stat1), 32'(RESET_STAT));
        chk({tag, "_f0_stat"}, 32'(stat0), 32'(RESET_STAT));
        chk({tag, "_f0_rvalid"}, 32'(f0_rvalid), 32'(0));
        chk({tag, "_f1_rvalid"}, 32'(f1_rvalid), 32'(0));
        chk({tag, "_f0_rdata"}, 32'(f0_rdata), 32'(0));
    endtask

    // Monitor: between edges compare flags, FWFT head word and registered-read scoreboard.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                chk("f1_status", 32'(stat1), 32'(exp_status()));
                chk("f0_status", 32'(stat0), 32'(exp_status()));
                chk("f1_rvalid", 32'(f1_rvalid), 32'(m_q.size() != 0));
                if (m_q.size() != 0) chk("f1_rdata", 32'(f1_rdata), 32'(m_q[0]));
                chk("f0_rvalid", 32'(f0_rvalid), 32'(m_rv0));
                if (m_rv0 && m_exp0.size() != 0) begin
                    e = m_exp0.pop_front();
                    chk("f0_rdata", 32'(f0_rdata), 32'(e));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb, rb;
        rst_n = 1'b0;
        {clr, winc, rinc, wdata} = '0;
        model_reset();
        repeat (3) cycle(0, 8'h00, 0, 0);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Fill 0x01..0x10, then one write too many.
        for (int i = 1; i <= 16; i++) cycle(1, 8'(i), 0, 0);
        chk("t1_fill16", 32'(f1_fill), 32'(16));
        chk("t1_wfull", 32'(f1_wfull), 32'(1));
        cycle(1, 8'hEE, 0, 0);
        chk("t1_fill_hold", 32'(f1_fill), 32'(16));
        chk("t1_overflow", 32'(f1_ovf), 32'(1));

        // Drain all 16, then one read too many.
        for (int i = 1; i <= 16; i++) cycle(0, 8'h00, 1, 0);
        chk("t2_rempty", 32'(f1_rempty), 32'(1));
        cycle(0, 8'h00, 1, 0);
        chk("t2_underflow", 32'(f1_unf), 32'(1));

        // Single word through the registered read path.
        cycle(0, 8'h00, 0, 1);
        cycle(1, 8'hA5, 0, 0);
        cycle(0, 8'h00, 0, 0);
        cycle(0, 8'h00, 1, 0);
        chk("t3_f0_rvalid", 32'(f0_rvalid), 32'(1));
        chk("t3_f0_rdata", 32'(f0_rdata), 32'(8'hA5));
        cycle(0, 8'h00, 0, 0);

        // Steady state at fill 8 with simultaneous push/pop; pointers wrap.
        for (int i = 0; i < 8; i++) cycle(1, 8'($urandom), 0, 0);
        for (int i = 0; i < 40; i++) cycle(1, 8'($urandom), 1, 0);
        chk("t4_fill8", 32'(f1_fill), 32'(8));
        for (int i = 0; i < 8; i++) cycle(0, 8'h00, 1, 0);

        // Full with push+pop -> read only; empty with push+pop -> write only.
        cycle(0, 8'h00, 0, 1);
        for (int i = 0; i < 16; i++) cycle(1, 8'($urandom), 0, 0);
        cycle(1, 8'h5A, 1, 0);
        chk("t5_fill15", 32'(f1_fill), 32'(15));
        chk("t5_overflow", 32'(f0_ovf), 32'(1));
        for (int i = 0; i < 15; i++) cycle(0, 8'h00, 1, 0);
        cycle(1, 8'h3C, 1, 0);
        chk("t5_fill1", 32'(f0_fill), 32'(1));
        chk("t5_underflow", 32'(f1_unf), 32'(1));

        // Flush at fill 9 with overflow set, write in the same cycle is dropped.
        cycle(0, 8'h00, 0, 1);
        for (int i = 0; i < 17; i++) cycle(1, 8'($urandom), 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 8'h00, 1, 0);
        chk("t6_fill9", 32'(f1_fill), 32'(9));
        cycle(1, 8'h77, 0, 1);
        chk("t6_clr_fill", 32'(f1_fill), 32'(0));
        chk("t6_clr_ovf", 32'(f0_ovf), 32'(0));
        chk("t6_clr_rempty", 32'(f0_rempty), 32'(1));

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 10; i++) cycle(1, 8'($urandom), i[0], 0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        model_reset();
        repeat (2) cycle(1, 8'hFF, 1, 0);
        rst_n = 1'b1;

        // Randomised traffic with drifting write/read bias and rare flushes.
        for (int blk = 0; blk < 12; blk++) begin
            wb = (blk % 3 == 0) ? 80 : (blk % 3 == 1) ? 20 : 50;
            rb = (blk % 3 == 0) ? 25 : (blk % 3 == 1) ? 80 : 50;
            for (int i = 0; i < 60; i++)
                cycle($urandom_range(99) < wb, 8'($urandom), $urandom_range(99) < rb,
                      $urandom_range(99) == 0);
        end

        for (int i = 0; i < 18; i++) cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 0);
        chk("sb_drained", 32'(m_exp0.size()), 32'(0));
        chk("end_empty", 32'(f0_rempty), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
